// File: rtl/hive_rbus_ctl_pkg.sv
// Shared widths and bus-request types for the hive register-bus controller.
package hive_rbus_ctl_pkg;

  localparam int HIVE_ADDR_W = 8;
  localparam int HIVE_ALU_W  = 32;

  typedef struct packed {
    logic                   rd;
    logic                   wr;
    logic                   host;
    logic [HIVE_ADDR_W-1:0] addr;
    logic [HIVE_ALU_W-1:0]  wr_data;
  } rbus_req_t;

  // Per-slot tag that travels alongside an access until its result stage.
  typedef struct packed {
    logic rd;
    logic host;
  } slot_tag_t;

endpackage

// File: rtl/hive_pipe.sv
// Plain delay line: DEPTH register stages of WIDTH bits, cleared by reset.
module hive_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q_o = r_stage[DEPTH-1];

endmodule

// File: rtl/hive_rbus_slot_arb.sv
// Slot arbiter: processor always wins; host launches into free slots when not busy,
// with a saturating wait counter that flags host starvation.
module hive_rbus_slot_arb #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cpu_req_i,
  input  logic host_req_i,
  input  logic host_done_i,
  output logic host_launch_o,
  output logic host_starve_o
);

  localparam int              CNT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

  logic             r_busy;
  logic [CNT_W-1:0] r_wait_cnt;

  assign host_launch_o = host_req_i & ~r_busy & ~cpu_req_i;

  // Busy spans launch through the ack cycle so only one host access is in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy <= 1'b0;
    end else if (host_launch_o) begin
      r_busy <= 1'b1;
    end else if (host_done_i) begin
      r_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait_cnt    <= '0;
      host_starve_o <= 1'b0;
    end else begin
      host_starve_o <= (r_wait_cnt == CNT_MAX);
      if (!host_req_i || host_launch_o) begin
        r_wait_cnt <= '0;
      end else if (!r_busy && cpu_req_i && r_wait_cnt != CNT_MAX) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hive_rbus_ctl.sv
// Register-bus controller: stage-0 slot decision, bus phase at +1, capture at +2,
// registered processor/host results at +3.
module hive_rbus_ctl
  import hive_rbus_ctl_pkg::*;
#(
  parameter int ADDR_W   = HIVE_ADDR_W,
  parameter int ALU_W    = HIVE_ALU_W,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_rd_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [ALU_W-1:0]  cpu_wr_data_i,
  output logic [ALU_W-1:0]  cpu_rd_data_3_o,
  output logic [ADDR_W-1:0] rbus_addr_o,
  output logic              rbus_wr_o,
  output logic              rbus_rd_o,
  output logic [ALU_W-1:0]  rbus_wr_data_o,
  input  logic [ALU_W-1:0]  rbus_rd_data_i,
  input  logic              host_req_i,
  input  logic              host_wr_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [ALU_W-1:0]  host_wr_data_i,
  output logic              host_ack_o,
  output logic [ALU_W-1:0]  host_rd_data_o,
  output logic              host_starve_o,
  output logic              err_o
);

  logic      w_cpu_req;
  logic      w_host_launch;
  rbus_req_t w_req;
  logic [1:0] w_tag_q;
  slot_tag_t w_tag_2;

  assign w_cpu_req = cpu_rd_i | cpu_wr_i;

  hive_rbus_slot_arb #(.WAIT_MAX(WAIT_MAX)) u_arb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cpu_req_i     (w_cpu_req),
    .host_req_i    (host_req_i),
    .host_done_i   (host_ack_o),
    .host_launch_o (w_host_launch),
    .host_starve_o (host_starve_o)
  );

  always_comb begin
    w_req = '0;
    if (w_cpu_req) begin
      // A simultaneous read+write degrades to the write alone.
      w_req.rd      = cpu_rd_i & ~cpu_wr_i;
      w_req.wr      = cpu_wr_i;
      w_req.addr    = cpu_addr_i;
      w_req.wr_data = cpu_wr_data_i;
    end else if (w_host_launch) begin
      w_req.rd      = ~host_wr_i;
      w_req.wr      = host_wr_i;
      w_req.host    = 1'b1;
      w_req.addr    = host_addr_i;
      w_req.wr_data = host_wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rbus_rd_o      <= 1'b0;
      rbus_wr_o      <= 1'b0;
      rbus_addr_o    <= '0;
      rbus_wr_data_o <= '0;
      err_o          <= 1'b0;
    end else begin
      rbus_rd_o <= w_req.rd;
      rbus_wr_o <= w_req.wr;
      if (w_req.rd || w_req.wr) begin
        rbus_addr_o    <= w_req.addr;
        rbus_wr_data_o <= w_req.wr_data;
      end
      err_o <= err_o | (cpu_rd_i & cpu_wr_i);
    end
  end

  hive_pipe #(.DEPTH(2), .WIDTH(2)) u_tag_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   ({w_req.rd, w_req.host}),
    .q_o   (w_tag_q)
  );

  assign w_tag_2 = slot_tag_t'(w_tag_q);

  // Read data on the bus this cycle belongs to the slot tagged two stages back.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cpu_rd_data_3_o <= '0;
      host_ack_o      <= 1'b0;
      host_rd_data_o  <= '0;
    end else begin
      cpu_rd_data_3_o <= (w_tag_2.rd && !w_tag_2.host) ? rbus_rd_data_i : '0;
      host_ack_o      <= w_tag_2.host;
      if (w_tag_2.host) begin
        host_rd_data_o <= w_tag_2.rd ? rbus_rd_data_i : '0;
      end
    end
  end

endmodule

// File: tb/tb_hive_rbus_ctl.sv
// Directed + randomized bench for hive_rbus_ctl against a cycle-indexed reference model.
module tb_hive_rbus_ctl;

  localparam int WAIT_MAX = 15;

  logic        clk_i;
  logic        rst_i;
  logic        cpu_rd_i, cpu_wr_i;
  logic [7:0]  cpu_addr_i;
  logic [31:0] cpu_wr_data_i;
  logic [31:0] cpu_rd_data_3_o;
  logic [7:0]  rbus_addr_o;
  logic        rbus_wr_o, rbus_rd_o;
  logic [31:0] rbus_wr_data_o;
  logic [31:0] rbus_rd_data_i;
  logic        host_req_i, host_wr_i;
  logic [7:0]  host_addr_i;
  logic [31:0] host_wr_data_i;
  logic        host_ack_o;
  logic [31:0] host_rd_data_o;
  logic        host_starve_o;
  logic        err_o;

  hive_rbus_ctl #(.ADDR_W(8), .ALU_W(32), .WAIT_MAX(WAIT_MAX)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cpu_rd_i        (cpu_rd_i),
    .cpu_wr_i        (cpu_wr_i),
    .cpu_addr_i      (cpu_addr_i),
    .cpu_wr_data_i   (cpu_wr_data_i),
    .cpu_rd_data_3_o (cpu_rd_data_3_o),
    .rbus_addr_o     (rbus_addr_o),
    .rbus_wr_o       (rbus_wr_o),
    .rbus_rd_o       (rbus_rd_o),
    .rbus_wr_data_o  (rbus_wr_data_o),
    .rbus_rd_data_i  (rbus_rd_data_i),
    .host_req_i      (host_req_i),
    .host_wr_i       (host_wr_i),
    .host_addr_i     (host_addr_i),
    .host_wr_data_i  (host_wr_data_i),
    .host_ack_o      (host_ack_o),
    .host_rd_data_o  (host_rd_data_o),
    .host_starve_o   (host_starve_o),
    .err_o           (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  // Reference model: scalars for next-cycle outputs, rings for results 3 cycles out.
  logic        e_rd, e_wr, e_err, e_starve;
  logic [7:0]  e_addr;
  logic [31:0] e_wd, hd_cur;
  logic [31:0] ring_cpu [8];
  logic [31:0] ring_hd [8];
  logic        ring_ack [8];
  logic        last_ack;
  int          free_from, m_cnt;
  // Peripheral: read-only register file answering one cycle after the read strobe.
  logic [31:0] mem [256];
  logic        p_rd;
  logic [7:0]  p_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    e_rd = 0; e_wr = 0; e_err = 0; e_starve = 0; e_addr = 0; e_wd = 0; hd_cur = 0;
    for (int i = 0; i < 8; i++) begin
      ring_cpu[i] = 0; ring_hd[i] = 0; ring_ack[i] = 0;
    end
    last_ack = 0; free_from = 0; m_cnt = 0; p_rd = 0; p_addr = 0;
  endtask

  task automatic drive_idle();
    cpu_rd_i = 0; cpu_wr_i = 0; cpu_addr_i = 0; cpu_wr_data_i = 0;
    host_req_i = 0; host_wr_i = 0; host_addr_i = 0; host_wr_data_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 1;
    drive_idle();
    #1;
    chk("rst_rbus_rd", rbus_rd_o, 0);
    chk("rst_rbus_wr", rbus_wr_o, 0);
    chk("rst_rbus_addr", rbus_addr_o, 0);
    chk("rst_rbus_wdata", rbus_wr_data_o, 0);
    chk("rst_cpu_rd_data_3", cpu_rd_data_3_o, 0);
    chk("rst_host_ack", host_ack_o, 0);
    chk("rst_host_rd_data", host_rd_data_o, 0);
    chk("rst_host_starve", host_starve_o, 0);
    chk("rst_err", err_o, 0);
    model_clear();
    @(negedge clk_i);
    cyc++;
    rst_i = 0;
  endtask

  // Called at a falling edge: check this cycle, drive stage-0 inputs, advance model.
  task automatic tick(input logic c_rd, input logic c_wr, input logic [7:0] c_addr,
                      input logic [31:0] c_wd, input logic h_req, input logic h_wr,
                      input logic [7:0] h_addr, input logic [31:0] h_wd);
    int  s_now, s3;
    logic cpu, launch, busy;
    s_now = cyc % 8;
    s3 = (cyc + 3) % 8;
    chk("rbus_rd", rbus_rd_o, e_rd);
    chk("rbus_wr", rbus_wr_o, e_wr);
    chk("rbus_addr", rbus_addr_o, e_addr);
    if (e_wr) chk("rbus_wdata", rbus_wr_data_o, e_wd);
    chk("cpu_rd_data_3", cpu_rd_data_3_o, ring_cpu[s_now]);
    chk("host_ack", host_ack_o, ring_ack[s_now]);
    if (ring_ack[s_now]) hd_cur = ring_hd[s_now];
    chk("host_rd_data", host_rd_data_o, hd_cur);
    chk("host_starve", host_starve_o, e_starve);
    chk("err", err_o, e_err);
    last_ack = ring_ack[s_now];
    ring_ack[s_now] = 0; ring_cpu[s_now] = 0; ring_hd[s_now] = 0;

    rbus_rd_data_i = p_rd ? mem[p_addr] : $urandom();
    p_rd = rbus_rd_o;
    p_addr = rbus_addr_o;

    cpu_rd_i = c_rd; cpu_wr_i = c_wr; cpu_addr_i = c_addr; cpu_wr_data_i = c_wd;
    host_req_i = h_req; host_wr_i = h_wr; host_addr_i = h_addr; host_wr_data_i = h_wd;

    cpu = c_rd | c_wr;
    busy = (cyc < free_from);
    launch = !cpu && h_req && !busy;
    e_starve = (m_cnt == WAIT_MAX);
    if (!h_req || launch) m_cnt = 0;
    else if (!busy && cpu && m_cnt < WAIT_MAX) m_cnt = m_cnt + 1;
    e_err = e_err | (c_rd & c_wr);
    if (cpu) begin
      e_rd = c_rd & !c_wr; e_wr = c_wr; e_addr = c_addr; e_wd = c_wd;
      ring_cpu[s3] = (c_rd && !c_wr) ? mem[c_addr] : 32'h0;
    end else if (launch) begin
      e_rd = !h_wr; e_wr = h_wr; e_addr = h_addr; e_wd = h_wd;
      ring_ack[s3] = 1;
      ring_hd[s3] = h_wr ? 32'h0 : mem[h_addr];
      free_from = cyc + 4;
    end else begin
      e_rd = 0; e_wr = 0;
    end
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
  endtask

  logic        h_on, h_wr_r;
  logic [7:0]  h_addr_r;
  logic [31:0] h_wd_r;
  int          r;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom();
    mem[8'h12] = 32'hDEADBEEF;
    mem[8'h40] = 32'h00000055;
    rst_i = 1;
    drive_idle();
    rbus_rd_data_i = 0;
    model_clear();
    @(negedge clk_i);
    do_reset();

    // CPU read with fixed 3-cycle latency
    tick(1, 0, 8'h12, 32'h0, 0, 0, 8'h00, 32'h0);
    idle(4);
    // Back-to-back CPU writes
    for (int i = 0; i < 4; i++) tick(0, 1, 8'(i), 32'hA0 + 32'(i), 0, 0, 8'h00, 32'h0);
    idle(3);
    // Host read held high: ack at +3, relaunch at +4
    for (int i = 0; i < 8; i++) tick(0, 0, 8'h00, 32'h0, 1, 0, 8'h40, 32'h0);
    idle(4);
    // Starvation: CPU owns 20 slots, then host gets the first idle one
    for (int i = 0; i < 20; i++)
      tick(1'($urandom_range(0, 1)) | 1'(i % 2), 1'(i % 2 == 0), 8'($urandom()), $urandom(),
           1, 1, 8'h20, 32'h1234);
    for (int i = 0; i < 4; i++) tick(0, 0, 8'h00, 32'h0, 1, 1, 8'h20, 32'h1234);
    idle(3);
    // Reset during a host read drops it; a new request then completes
    tick(0, 0, 8'h00, 32'h0, 1, 0, 8'h41, 32'h0);
    tick(0, 0, 8'h00, 32'h0, 1, 0, 8'h41, 32'h0);
    do_reset();
    idle(4);
    for (int i = 0; i < 4; i++) tick(0, 0, 8'h00, 32'h0, 1, 0, 8'h41, 32'h0);
    idle(3);

    // Randomized traffic with a host agent holding req until ack
    h_on = 0; h_wr_r = 0; h_addr_r = 0; h_wd_r = 0;
    for (int i = 0; i < 400; i++) begin
      if (!h_on && $urandom_range(0, 3) == 0) begin
        h_on = 1; h_wr_r = 1'($urandom_range(0, 1));
        h_addr_r = 8'($urandom()); h_wd_r = $urandom();
      end
      r = $urandom_range(0, 9);
      tick(r < 3, r >= 3 && r < 6, 8'($urandom()), $urandom(), h_on, h_wr_r, h_addr_r, h_wd_r);
      if (last_ack) h_on = 0;
    end
    idle(4);

    // Illegal read+write: write only, sticky error until reset
    tick(1, 1, 8'h05, 32'h77, 0, 0, 8'h00, 32'h0);
    idle(5);
    do_reset();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
